// File: rtl/p09_spi_master.sv
// SPI mode-0 initiator: sends a 16-bit command (repeated every frame) and reads back STATE_SIZE bits.
// Optional build macro P09_SPIM_MISO_SYNC_EN adds a 2-flop synchronizer on miso_i.
module p09_spi_master #(
    parameter int unsigned STATE_SIZE = 41,
    parameter int unsigned CLK_DIV    = 4
) (
    input  logic                  clk,
    input  logic                  nRst,
    input  logic                  start_i,
    input  logic [15:0]           write_value_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [STATE_SIZE-1:0] state_out_o,
    output logic                  sck_o,
    output logic                  ss_o,
    output logic                  mosi_o,
    input  logic                  miso_i
);
    localparam int unsigned NWORDS = (STATE_SIZE + 15) / 16;
    localparam int unsigned NBITS  = 16 * NWORDS;
    localparam int unsigned CntW   = $clog2(NBITS + 1);
    localparam int unsigned PhW    = $clog2(CLK_DIV);

    localparam logic [PhW-1:0]  PhLast    = PhW'(CLK_DIV - 1);
    localparam logic [PhW-1:0]  PhGapLast = PhW'(CLK_DIV - 2);
    localparam logic [CntW-1:0] CntBits   = CntW'(NBITS);
    localparam logic [CntW-1:0] CntState  = CntW'(STATE_SIZE);

    typedef enum logic [2:0] {StIdle, StSetup, StHigh, StLow, StHold, StGap} state_e;

    state_e                state_q, state_d;
    logic [PhW-1:0]        phase_q, phase_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [15:0]           word_q, word_d;
    logic [STATE_SIZE-1:0] rx_q, rx_d;
    logic [STATE_SIZE-1:0] state_out_q, state_out_d;
    logic                  sck_q, sck_d;
    logic                  ss_q, ss_d;
    logic                  mosi_q, mosi_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  miso_s;
    logic                  phase_last;

`ifdef P09_SPIM_MISO_SYNC_EN
    logic [1:0] sync_q;
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) sync_q <= '0;
        else       sync_q <= {sync_q[0], miso_i};
    end
    assign miso_s = sync_q[1];
`else
    assign miso_s = miso_i;
`endif

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        cnt_d       = cnt_q;
        word_d      = word_q;
        rx_d        = rx_q;
        state_out_d = state_out_q;
        sck_d       = sck_q;
        ss_d        = ss_q;
        mosi_d      = mosi_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        phase_last  = (phase_q == PhLast);
        if (state_q != StIdle) phase_d = phase_last ? '0 : phase_q + 1'b1;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    word_d  = write_value_i;
                    ss_d    = 1'b0;
                    busy_d  = 1'b1;
                    mosi_d  = write_value_i[15];
                    cnt_d   = '0;
                    state_d = StSetup;
                end
            end
            StSetup: begin
                if (phase_last) begin
                    sck_d   = 1'b1;
                    state_d = StHigh;
                end
            end
            StHigh: begin
                if (phase_last) begin
                    // Only the first STATE_SIZE bits are kept; trailing fill bits fall away.
                    if (cnt_q < CntState) rx_d = {rx_q[STATE_SIZE-2:0], miso_s};
                    sck_d   = 1'b0;
                    cnt_d   = cnt_q + 1'b1;
                    // 15 - (k mod 16) is the bitwise inverse of the low nibble.
                    if (cnt_d != CntBits) mosi_d = word_q[~cnt_d[3:0]];
                    state_d = StLow;
                end
            end
            StLow: begin
                // The final low half-period completes the last sck cycle before HOLD.
                if (phase_last) begin
                    if (cnt_q == CntBits) begin
                        state_d = StHold;
                    end else begin
                        sck_d   = 1'b1;
                        state_d = StHigh;
                    end
                end
            end
            StHold: begin
                if (phase_last) begin
                    ss_d    = 1'b1;
                    mosi_d  = 1'b0;
                    state_d = StGap;
                end
            end
            StGap: begin
                // done is registered, so it is raised one cycle early to land on the gap's last cycle.
                if (phase_q == PhGapLast) begin
                    state_out_d = rx_q;
                    done_d      = 1'b1;
                    busy_d      = 1'b0;
                    phase_d     = '0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q     <= StIdle;
            phase_q     <= '0;
            cnt_q       <= '0;
            word_q      <= '0;
            rx_q        <= '0;
            state_out_q <= '0;
            sck_q       <= 1'b0;
            ss_q        <= 1'b1;
            mosi_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            cnt_q       <= cnt_d;
            word_q      <= word_d;
            rx_q        <= rx_d;
            state_out_q <= state_out_d;
            sck_q       <= sck_d;
            ss_q        <= ss_d;
            mosi_q      <= mosi_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign state_out_o = state_out_q;
    assign sck_o       = sck_q;
    assign ss_o        = ss_q;
    assign mosi_o      = mosi_q;
endmodule

// File: tb/tb_p09_spi_master.sv
// Bench for p09_spi_master: behavioural SPI responder, vector table, random transactions, corner cases.
module tb_p09_spi_master;
`ifdef P09_SPIM_MISO_SYNC_EN
    localparam int CD   = 3;
    localparam int SKEW = 1;
`else
    localparam int CD   = 4;
    localparam int SKEW = 0;
`endif
    localparam int SS      = 41;
    localparam int NBITS   = 16 * ((SS + 15) / 16);
    localparam int SS_LOW  = CD * (2 + 2 * NBITS);
    localparam int DONE_AT = CD * (3 + 2 * NBITS) - 1;

    logic          clk = 1'b0;
    logic          nRst = 1'b1;
    logic          start = 1'b0;
    logic [15:0]   wv = '0;
    logic          miso = 1'b0;
    logic          busy, done, sck, ss, mosi;
    logic [SS-1:0] state_out;

    p09_spi_master #(.STATE_SIZE(SS), .CLK_DIV(CD)) dut (
        .clk          (clk),
        .nRst         (nRst),
        .start_i      (start),
        .write_value_i(wv),
        .busy_o       (busy),
        .done_o       (done),
        .state_out_o  (state_out),
        .sck_o        (sck),
        .ss_o         (ss),
        .mosi_o       (mosi),
        .miso_i       (miso)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Responder: one queued frame per ss fall, MSB first, advances after each sck fall.
    logic [NBITS-1:0] resp_q[$];
    logic [NBITS-1:0] resp_bits = '0;
    int               resp_idx = 0;

    always @(negedge ss) begin
        resp_bits = (resp_q.size() > 0) ? resp_q.pop_front() : '0;
        resp_idx  = 0;
        miso      = resp_bits[NBITS-1];
    end

    always @(negedge sck) begin
        if (ss == 1'b0) begin
            repeat (SKEW) @(posedge clk);
            #1;
            resp_idx++;
            if (resp_idx < NBITS) miso = resp_bits[NBITS-1-resp_idx];
        end
    end

    task automatic push_resp(input logic [SS-1:0] st, input logic fill);
        logic [NBITS-1:0] w;
        w = '0;
        w[NBITS-1 -: SS] = st;
        for (int i = 0; i < NBITS - SS; i++) w[i] = fill;
        resp_q.push_back(w);
    endtask

    // Monitor, sampled on the falling clk edge.
    int            rise_cnt = 0;
    int            busy_cnt = 0;
    logic          mosi_bits[$];
    int            fall_cs[$];
    int            rise_cs[$];
    int            done_cs[$];
    logic [SS-1:0] done_vals[$];
    logic          sck_prev = 1'b0;
    logic          ss_prev = 1'b1;

    always @(negedge clk) begin
        if (sck === 1'b1 && sck_prev === 1'b0) begin
            rise_cnt++;
            mosi_bits.push_back(mosi);
        end
        if (ss === 1'b0 && ss_prev === 1'b1) fall_cs.push_back(cyc);
        if (ss === 1'b1 && ss_prev === 1'b0) rise_cs.push_back(cyc);
        if (done === 1'b1) begin
            done_cs.push_back(cyc);
            done_vals.push_back(state_out);
        end
        if (busy === 1'b1) busy_cnt++;
        sck_prev = sck;
        ss_prev  = ss;
    end

    task automatic clear_mon();
        rise_cnt = 0;
        busy_cnt = 0;
        mosi_bits.delete();
        fall_cs.delete();
        rise_cs.delete();
        done_cs.delete();
        done_vals.delete();
    endtask

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int mosi_errors(input logic [15:0] w);
        int errs = 0;
        if (mosi_bits.size() != NBITS) return NBITS;
        for (int k = 0; k < NBITS; k++)
            if (mosi_bits[k] !== w[15 - (k % 16)]) errs++;
        return errs;
    endfunction

    // Launch one transaction and wait (bounded) until its done has been seen.
    task automatic do_txn(input logic [15:0] w, output int c0);
        bit got = 1'b0;
        @(posedge clk); #1;
        clear_mon();
        wv    = w;
        start = 1'b1;
        c0    = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        wv    = 16'($urandom);
        for (int i = 0; i < DONE_AT + 50 && !got; i++) begin
            @(posedge clk); #1;
            if (done_cs.size() > 0) got = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_txn(input string tag, input logic [15:0] w, input logic [SS-1:0] st,
                             input int c0, input bit full);
        check({tag, "_state_out"}, 64'(state_out), 64'(st));
        check({tag, "_done_count"}, 64'(done_cs.size()), 64'd1);
        check({tag, "_mosi_errs"}, 64'(mosi_errors(w)), 64'd0);
        if (full) begin
            check({tag, "_done_time"}, 64'(qget(done_cs, 0)), 64'(c0 + 1 + DONE_AT));
            check({tag, "_ss_fall"}, 64'(qget(fall_cs, 0)), 64'(c0 + 1));
            check({tag, "_ss_low"}, 64'(qget(rise_cs, 0) - qget(fall_cs, 0)), 64'(SS_LOW));
            check({tag, "_sck_rises"}, 64'(rise_cnt), 64'(NBITS));
            check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(DONE_AT));
            check({tag, "_idle_pins"}, {61'd0, ss, sck, mosi}, 64'b100);
        end
    endtask

    typedef struct {
        logic [15:0]   w;
        logic [SS-1:0] st;
        logic          fill;
        logic [SS-1:0] exp_state;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int c0;
        logic [15:0]   w;
        logic [SS-1:0] st, st2;
        bit            reached;

        vecs[0] = '{16'hA5C3, 41'h1_2345_6789A, 1'b1, 41'h1_2345_6789A};
        vecs[1] = '{16'h0000, {SS{1'b1}},       1'b0, {SS{1'b1}}};
        vecs[2] = '{16'hFFFF, '0,               1'b1, '0};
        vecs[3] = '{16'h8001, 41'h100_0000_0001, 1'b0, 41'h100_0000_0001};

        #1 nRst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ss", 64'(ss), 64'd1);
        check("reset_sck", 64'(sck), 64'd0);
        check("reset_mosi", 64'(mosi), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_state_out", 64'(state_out), 64'd0);
        nRst = 1'b1;

        for (int v = 0; v < 4; v++) begin
            push_resp(vecs[v].st, vecs[v].fill);
            do_txn(vecs[v].w, c0);
            check_txn($sformatf("vec%0d", v), vecs[v].w, vecs[v].exp_state, c0, 1'b1);
        end

        for (int r = 0; r < 5; r++) begin
            w  = 16'($urandom);
            st = SS'({$urandom, $urandom});
            push_resp(st, 1'($urandom));
            do_txn(w, c0);
            check_txn($sformatf("rand%0d", r), w, st, c0, (r == 0));
        end

        // start pulses while busy must be ignored
        st = SS'({$urandom, $urandom});
        push_resp(st, 1'b1);
        @(posedge clk); #1;
        clear_mon();
        wv = 16'h3C5A;
        start = 1'b1;
        c0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        for (int p = 0; p < 7; p++) begin
            repeat (49) @(posedge clk);
            #1 start = 1'b1;
            wv = 16'hFFFF;
            @(posedge clk); #1;
            start = 1'b0;
        end
        repeat (200) @(posedge clk);
        #1;
        check("pulses_ss_falls", 64'(fall_cs.size()), 64'd1);
        check_txn("pulses", 16'h3C5A, st, c0, 1'b0);

        // reset in the middle of a transaction
        push_resp(41'h0AB_CDEF_0123, 1'b0);
        @(posedge clk); #1;
        clear_mon();
        wv = 16'h1234;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        reached = 1'b0;
        for (int i = 0; i < 40 * CD * 2 && !reached; i++) begin
            @(negedge clk); #1;
            if (rise_cnt >= 20) reached = 1'b1;
        end
        check("abort_reached_rise20", 64'(reached), 64'd1);
        nRst = 1'b0;
        #1;
        check("abort_ss", 64'(ss), 64'd1);
        check("abort_sck_busy", {62'd0, sck, busy}, 64'd0);
        check("abort_state_out", 64'(state_out), 64'd0);
        repeat (2) @(negedge clk);
        #1 nRst = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("abort_no_done", 64'(done_cs.size()), 64'd0);
        st = 41'h155_5555_5555;
        push_resp(st, 1'b1);
        do_txn(16'h5AA5, c0);
        check_txn("after_abort", 16'h5AA5, st, c0, 1'b1);

        // start held high: back-to-back transactions
        st  = SS'({$urandom, $urandom});
        st2 = ~st;
        push_resp(st, 1'b1);
        push_resp(st2, 1'b0);
        @(posedge clk); #1;
        clear_mon();
        wv = 16'hC001;
        start = 1'b1;
        for (int i = 0; i < 3 * DONE_AT && done_cs.size() < 2; i++) begin
            @(negedge clk); #1;
        end
        start = 1'b0;
        repeat (DONE_AT + 20) @(posedge clk);
        #1;
        check("b2b_done_count", 64'(done_cs.size()), 64'd2);
        check("b2b_first_value", 64'((done_vals.size() > 0) ? done_vals[0] : ~st), 64'(st));
        check("b2b_second_value", 64'((done_vals.size() > 1) ? done_vals[1] : ~st2), 64'(st2));
        check("b2b_restart_time", 64'(qget(fall_cs, 1)), 64'(qget(done_cs, 0) + 1));
        check("b2b_gap_ge_div", 64'((qget(fall_cs, 1) - qget(rise_cs, 0)) >= CD), 64'd1);
        check("b2b_final_state_out", 64'(state_out), 64'(st2));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
